// File: rtl/cache_wb_pkg.sv
// Shared types and width helpers for the write-back cache controller.
package cache_wb_pkg;

  typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE} state_e;

  // Byte-offset bits inside a word (ignored by the cache).
  function automatic int off_bits(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  // Word-select bits inside a line (0 when a line is a single word).
  function automatic int word_bits(input int words);
    return $clog2(words);
  endfunction

  function automatic int idx_bits(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_bits(input int addr_w, data_w, words, lines);
    return addr_w - off_bits(data_w) - word_bits(words) - idx_bits(lines);
  endfunction

  // Beat counter / word index width, kept at least one bit wide.
  function automatic int beat_bits(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/cache_line_store.sv
// Line storage: valid/dirty/tag/data arrays with one read and one write port.
module cache_line_store
  import cache_wb_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int NUM_LINES      = 16,
  parameter int WORDS_PER_LINE = 4,
  parameter int TAG_W          = 24,
  localparam int IDX_W         = idx_bits(NUM_LINES),
  localparam int BEAT_W        = beat_bits(WORDS_PER_LINE)
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [IDX_W-1:0]                          rd_idx_i,
  output logic                                      rd_valid_o,
  output logic                                      rd_dirty_o,
  output logic [TAG_W-1:0]                          rd_tag_o,
  output logic [WORDS_PER_LINE-1:0][DATA_W-1:0]     rd_line_o,
  input  logic [IDX_W-1:0]                          wr_idx_i,
  input  logic                                      data_we_i,
  input  logic [BEAT_W-1:0]                         wr_word_i,
  input  logic [DATA_W-1:0]                         wr_data_i,
  input  logic                                      meta_we_i,
  input  logic                                      meta_valid_i,
  input  logic                                      meta_dirty_i,
  input  logic [TAG_W-1:0]                          meta_tag_i
);

  logic [NUM_LINES-1:0]                  valid_q;
  logic [NUM_LINES-1:0]                  dirty_q;
  logic [TAG_W-1:0]                      tag_q  [NUM_LINES];
  logic [WORDS_PER_LINE-1:0][DATA_W-1:0] data_q [NUM_LINES];

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_dirty_o = dirty_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_line_o  = data_q[rd_idx_i];

  // Status bits are the only reset state; an invalid line hides stale tag/data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (meta_we_i) begin
      valid_q[wr_idx_i] <= meta_valid_i;
      dirty_q[wr_idx_i] <= meta_dirty_i;
    end
  end

  // Tag and data arrays, no reset.
  always_ff @(posedge clk) begin
    if (meta_we_i) tag_q[wr_idx_i] <= meta_tag_i;
    if (data_we_i) data_q[wr_idx_i][wr_word_i] <= wr_data_i;
  end

endmodule

// File: rtl/cache_ctrl_wb.sv
// Direct-mapped write-back / write-allocate cache controller with burst
// eviction and fill over a word-wide ready/ack memory port.
module cache_ctrl_wb
  import cache_wb_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int NUM_LINES      = 16,
  parameter int WORDS_PER_LINE = 4,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam int OFF_W   = off_bits(DATA_W);
  localparam int WRD_W   = word_bits(WORDS_PER_LINE);
  localparam int IDX_W   = idx_bits(NUM_LINES);
  localparam int TAG_W   = tag_bits(ADDR_W, DATA_W, WORDS_PER_LINE, NUM_LINES);
  localparam int BEAT_W  = beat_bits(WORDS_PER_LINE);
  localparam int IDX_LSB = OFF_W + WRD_W;
  localparam int TAG_LSB = IDX_LSB + IDX_W;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_LINE - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  state_e              state_q;
  logic                req_we_q, first_q;
  logic [ADDR_W-1:0]   req_addr_q;
  logic [DATA_W-1:0]   req_wdata_q;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic                cpu_ready_q, mem_req_q, mem_we_q;
  logic [DATA_W-1:0]   cpu_rdata_q, mem_wdata_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [CNT_W-1:0]    hit_cnt_q, miss_cnt_q;

  logic [IDX_W-1:0]    req_idx;
  logic [TAG_W-1:0]    req_tag;
  logic [BEAT_W-1:0]   req_word;
  logic                rd_valid, rd_dirty, hit, beat_ack, last_beat;
  logic [TAG_W-1:0]    rd_tag;
  logic [WORDS_PER_LINE-1:0][DATA_W-1:0] rd_line;
  logic                data_we, meta_we, meta_dirty;
  logic [BEAT_W-1:0]   wr_word;
  logic [DATA_W-1:0]   wr_data;
  logic [TAG_W-1:0]    meta_tag;

  assign req_idx   = IDX_W'(req_addr_q >> IDX_LSB);
  assign req_tag   = TAG_W'(req_addr_q >> TAG_LSB);
  assign req_word  = BEAT_W'((req_addr_q >> OFF_W) & ADDR_W'(WORDS_PER_LINE - 1));
  assign hit       = rd_valid && (rd_tag == req_tag);
  assign beat_ack  = mem_req_q && mem_ack;
  assign last_beat = (beat_q == LAST_BEAT);
  assign beat_d    = last_beat ? '0 : beat_q + 1'b1;

  function automatic logic [ADDR_W-1:0] beat_addr(input logic [TAG_W-1:0]  tag,
                                                  input logic [IDX_W-1:0]  idx,
                                                  input logic [BEAT_W-1:0] beat);
    return (ADDR_W'(tag) << TAG_LSB) | (ADDR_W'(idx) << IDX_LSB) | (ADDR_W'(beat) << OFF_W);
  endfunction

  cache_line_store #(
    .DATA_W(DATA_W), .NUM_LINES(NUM_LINES),
    .WORDS_PER_LINE(WORDS_PER_LINE), .TAG_W(TAG_W)
  ) u_store (
    .clk(clk), .reset(reset),
    .rd_idx_i(req_idx), .rd_valid_o(rd_valid), .rd_dirty_o(rd_dirty),
    .rd_tag_o(rd_tag), .rd_line_o(rd_line),
    .wr_idx_i(req_idx), .data_we_i(data_we), .wr_word_i(wr_word), .wr_data_i(wr_data),
    .meta_we_i(meta_we), .meta_valid_i(1'b1), .meta_dirty_i(meta_dirty), .meta_tag_i(meta_tag)
  );

  // Store write control: write hits, fill beats, and line status updates.
  always_comb begin
    data_we    = 1'b0;
    meta_we    = 1'b0;
    wr_word    = req_word;
    wr_data    = req_wdata_q;
    meta_dirty = 1'b0;
    meta_tag   = req_tag;
    case (state_q)
      COMPARE: begin
        data_we    = hit && req_we_q;
        meta_we    = hit && req_we_q;
        meta_dirty = 1'b1;
      end
      WRITEBACK: begin
        // Line stays valid under its old tag; only dirty is dropped.
        meta_we  = beat_ack && last_beat;
        meta_tag = rd_tag;
      end
      ALLOCATE: begin
        data_we = beat_ack;
        wr_word = beat_q;
        wr_data = mem_rdata;
        meta_we = beat_ack && last_beat;
      end
      default: ;
    endcase
  end

  // Main FSM with registered CPU/memory outputs and saturating counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      first_q     <= 1'b0;
      beat_q      <= '0;
      cpu_ready_q <= 1'b0;
      cpu_rdata_q <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      cpu_ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // The CPU still holds the finished request during the ready cycle.
          if (cpu_req && !cpu_ready_q) begin
            req_we_q    <= cpu_we;
            req_addr_q  <= cpu_addr;
            req_wdata_q <= cpu_wdata;
            first_q     <= 1'b1;
            state_q     <= COMPARE;
          end
        end
        COMPARE: begin
          first_q <= 1'b0;
          if (hit) begin
            cpu_ready_q <= 1'b1;
            cpu_rdata_q <= req_we_q ? req_wdata_q : rd_line[req_word];
            if (first_q && hit_cnt_q != CNT_MAX) hit_cnt_q <= hit_cnt_q + 1'b1;
            state_q <= IDLE;
          end else begin
            if (first_q && miss_cnt_q != CNT_MAX) miss_cnt_q <= miss_cnt_q + 1'b1;
            beat_q    <= '0;
            mem_req_q <= 1'b1;
            if (rd_dirty) begin
              mem_we_q    <= 1'b1;
              mem_addr_q  <= beat_addr(rd_tag, req_idx, '0);
              mem_wdata_q <= rd_line[0];
              state_q     <= WRITEBACK;
            end else begin
              mem_we_q   <= 1'b0;
              mem_addr_q <= beat_addr(req_tag, req_idx, '0);
              state_q    <= ALLOCATE;
            end
          end
        end
        WRITEBACK: begin
          if (beat_ack) begin
            beat_q <= beat_d;
            if (last_beat) begin
              mem_we_q   <= 1'b0;
              mem_addr_q <= beat_addr(req_tag, req_idx, '0);
              state_q    <= ALLOCATE;
            end else begin
              mem_addr_q  <= beat_addr(rd_tag, req_idx, beat_d);
              mem_wdata_q <= rd_line[beat_d];
            end
          end
        end
        ALLOCATE: begin
          if (beat_ack) begin
            beat_q <= beat_d;
            if (last_beat) begin
              mem_req_q <= 1'b0;
              state_q   <= COMPARE;
            end else begin
              mem_addr_q <= beat_addr(req_tag, req_idx, beat_d);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cpu_ready = cpu_ready_q;
  assign cpu_rdata = cpu_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;

endmodule

// File: tb/tb_cache_ctrl_wb.sv
// Directed bench for cache_ctrl_wb: memory responder with configurable ack
// delay, beat log, and a second instance with 2-bit counters run in lockstep.
module tb_cache_ctrl_wb;

  logic        clk, reset;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_ready;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [15:0] hit_cnt, miss_cnt;
  logic [31:0] d2_cpu_rdata, d2_mem_addr, d2_mem_wdata;
  logic        d2_cpu_ready, d2_mem_req, d2_mem_we;
  logic [1:0]  d2_hit_cnt, d2_miss_cnt;

  int checks = 0;
  int errors = 0;

  cache_ctrl_wb dut (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  cache_ctrl_wb #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(d2_cpu_rdata), .cpu_ready(d2_cpu_ready),
    .mem_req(d2_mem_req), .mem_we(d2_mem_we), .mem_addr(d2_mem_addr), .mem_wdata(d2_mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .hit_cnt(d2_hit_cnt), .miss_cnt(d2_miss_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- memory model and responder ----------------
  logic [31:0] mem_wr [logic [31:0]];
  bit          log_we   [$];
  logic [31:0] log_addr [$];
  logic [31:0] log_data [$];
  int          ack_dly   = 1;
  bit          force_ack = 0;
  int          wait_cnt  = 0;
  int          stab_err  = 0;
  logic [31:0] hold_addr, hold_wdata;
  logic        hold_we;

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    if (mem_wr.exists(a)) return mem_wr[a];
    return 32'h1000_0000 + a;
  endfunction

  always @(negedge clk) begin
    if (mem_req) begin
      if (wait_cnt == 0) begin
        hold_addr = mem_addr; hold_wdata = mem_wdata; hold_we = mem_we;
      end else if (mem_addr !== hold_addr || mem_wdata !== hold_wdata || mem_we !== hold_we) begin
        stab_err++;
      end
      if (wait_cnt == ack_dly - 1) begin
        mem_ack = 1'b1;
        wait_cnt = 0;
        log_we.push_back(mem_we);
        log_addr.push_back(mem_addr);
        if (mem_we) begin
          mem_wr[mem_addr] = mem_wdata;
          log_data.push_back(mem_wdata);
        end else begin
          mem_rdata = model_rd(mem_addr);
          log_data.push_back(mem_rdata);
        end
      end else begin
        mem_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      mem_ack = force_ack;
      wait_cnt = 0;
    end
  end

  task automatic clear_log();
    log_we.delete(); log_addr.delete(); log_data.delete();
  endtask

  // One CPU transaction; lat is the cycle cpu_ready is seen (sampling edge = 0), -1 on timeout.
  task automatic cpu_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output int lat);
    @(posedge clk);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    lat = -1; rdata = '0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      if (cpu_ready) begin
        lat = c; rdata = cpu_rdata;
        break;
      end
    end
    cpu_req = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    checks++; if (cpu_ready !== 1'b0) begin errors++; $display("FAIL reset_cpu_ready got %h exp 0", cpu_ready); end
    checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL reset_cpu_rdata got %h exp 0", cpu_rdata); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %h exp 0", mem_req); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %h exp 0", mem_we); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr got %h exp 0", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata got %h exp 0", mem_wdata); end
    checks++; if (hit_cnt !== 16'h0) begin errors++; $display("FAIL reset_hit_cnt got %0d exp 0", hit_cnt); end
    checks++; if (miss_cnt !== 16'h0) begin errors++; $display("FAIL reset_miss_cnt got %0d exp 0", miss_cnt); end
  endtask

  task automatic test_cold_write();
    logic [31:0] rd; int lat;
    clear_log();
    cpu_access(1'b1, 32'h0, 32'hA5, rd, lat);
    checks++; if (lat !== 6) begin errors++; $display("FAIL cold_write_latency got %0d exp 6", lat); end
    checks++; if (log_addr.size() !== 4) begin errors++; $display("FAIL cold_write_beats got %0d exp 4", log_addr.size()); end
    if (log_addr.size() == 4)
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (log_we[i] !== 1'b0 || log_addr[i] !== 32'(4 * i)) begin
          errors++; $display("FAIL cold_write_beat%0d got we=%0d addr=%h exp we=0 addr=%h", i, log_we[i], log_addr[i], 4 * i);
        end
      end
    checks++; if (miss_cnt !== 16'd1) begin errors++; $display("FAIL cold_write_miss_cnt got %0d exp 1", miss_cnt); end
    checks++; if (hit_cnt !== 16'd0) begin errors++; $display("FAIL cold_write_hit_cnt got %0d exp 0", hit_cnt); end
  endtask

  task automatic test_read_hit();
    logic [31:0] rd; int lat;
    clear_log();
    cpu_access(1'b0, 32'h0, 32'h0, rd, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL read_hit_latency got %0d exp 1", lat); end
    checks++; if (rd !== 32'hA5) begin errors++; $display("FAIL read_hit_data got %h exp a5", rd); end
    checks++; if (hit_cnt !== 16'd1) begin errors++; $display("FAIL read_hit_hit_cnt got %0d exp 1", hit_cnt); end
    checks++; if (log_addr.size() !== 0) begin errors++; $display("FAIL read_hit_no_mem got %0d beats exp 0", log_addr.size()); end
  endtask

  task automatic test_dirty_evict();
    logic [31:0] rd; int lat;
    bit          ewe   [8] = '{1, 1, 1, 1, 0, 0, 0, 0};
    logic [31:0] eaddr [8] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h100, 32'h104, 32'h108, 32'h10C};
    logic [31:0] edata [4] = '{32'hA5, 32'h1000_0004, 32'h1000_0008, 32'h1000_000C};
    clear_log();
    cpu_access(1'b0, 32'h100, 32'h0, rd, lat);
    checks++; if (lat !== 10) begin errors++; $display("FAIL evict_latency got %0d exp 10", lat); end
    checks++; if (rd !== 32'h1000_0100) begin errors++; $display("FAIL evict_rdata got %h exp 10000100", rd); end
    checks++; if (miss_cnt !== 16'd2) begin errors++; $display("FAIL evict_miss_cnt got %0d exp 2", miss_cnt); end
    checks++; if (log_addr.size() !== 8) begin errors++; $display("FAIL evict_beats got %0d exp 8", log_addr.size()); end
    if (log_addr.size() == 8)
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (log_we[i] !== ewe[i] || log_addr[i] !== eaddr[i] || (i < 4 && log_data[i] !== edata[i & 3])) begin
          errors++;
          $display("FAIL evict_beat%0d got we=%0d addr=%h data=%h exp we=%0d addr=%h", i, log_we[i], log_addr[i], log_data[i], ewe[i], eaddr[i]);
        end
      end
  endtask

  task automatic test_fill_lines();
    logic [31:0] rd, a; int lat, nwr;
    clear_log();
    for (int i = 0; i < 8; i++) begin
      a = 32'h20 + 32'(4 * i);
      cpu_access(1'b1, a, 32'hB000_0000 + a, rd, lat);
      checks++;
      if (lat !== ((i == 0 || i == 4) ? 6 : 1)) begin
        errors++; $display("FAIL fill_write_latency addr=%h got %0d exp %0d", a, lat, (i == 0 || i == 4) ? 6 : 1);
      end
    end
    for (int i = 0; i < 8; i++) begin
      a = 32'h20 + 32'(4 * i);
      cpu_access(1'b0, a, 32'h0, rd, lat);
      checks++;
      if (rd !== 32'hB000_0000 + a || lat !== 1) begin
        errors++; $display("FAIL fill_readback addr=%h got data=%h lat=%0d exp data=%h lat=1", a, rd, lat, 32'hB000_0000 + a);
      end
    end
    nwr = 0;
    foreach (log_we[i]) if (log_we[i]) nwr++;
    checks++; if (log_addr.size() !== 8 || nwr !== 0) begin errors++; $display("FAIL fill_clean_only got %0d beats %0d writes exp 8 beats 0 writes", log_addr.size(), nwr); end
    checks++; if (hit_cnt !== 16'd15) begin errors++; $display("FAIL fill_hit_cnt got %0d exp 15", hit_cnt); end
    checks++; if (miss_cnt !== 16'd4) begin errors++; $display("FAIL fill_miss_cnt got %0d exp 4", miss_cnt); end
  endtask

  task automatic test_delayed_ack();
    logic [31:0] rd; int lat;
    logic [31:0] eaddr [4] = '{32'h200, 32'h204, 32'h208, 32'h20C};
    logic [31:0] edata [4] = '{32'h1000_0200, 32'hCAFE_0204, 32'h1000_0208, 32'h1000_020C};
    stab_err = 0;
    ack_dly = 3;
    cpu_access(1'b0, 32'h200, 32'h0, rd, lat);
    checks++; if (lat !== 14) begin errors++; $display("FAIL slow_clean_latency got %0d exp 14", lat); end
    checks++; if (rd !== 32'h1000_0200) begin errors++; $display("FAIL slow_clean_rdata got %h exp 10000200", rd); end
    ack_dly = 1;
    cpu_access(1'b1, 32'h204, 32'hCAFE_0204, rd, lat);
    checks++; if (lat !== 1 || hit_cnt !== 16'd16) begin errors++; $display("FAIL slow_setup_hit got lat=%0d hits=%0d exp lat=1 hits=16", lat, hit_cnt); end
    ack_dly = 3;
    clear_log();
    cpu_access(1'b0, 32'h300, 32'h0, rd, lat);
    ack_dly = 1;
    checks++; if (lat !== 26) begin errors++; $display("FAIL slow_dirty_latency got %0d exp 26", lat); end
    checks++; if (rd !== 32'h1000_0300) begin errors++; $display("FAIL slow_dirty_rdata got %h exp 10000300", rd); end
    checks++; if (log_addr.size() !== 8) begin errors++; $display("FAIL slow_dirty_beats got %0d exp 8", log_addr.size()); end
    if (log_addr.size() == 8)
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (log_we[i] !== 1'b1 || log_addr[i] !== eaddr[i] || log_data[i] !== edata[i]) begin
          errors++; $display("FAIL slow_wb_beat%0d got we=%0d addr=%h data=%h exp we=1 addr=%h data=%h", i, log_we[i], log_addr[i], log_data[i], eaddr[i], edata[i]);
        end
      end
    checks++; if (stab_err !== 0) begin errors++; $display("FAIL slow_beat_stability got %0d changes exp 0", stab_err); end
    checks++; if (miss_cnt !== 16'd6) begin errors++; $display("FAIL slow_miss_cnt got %0d exp 6", miss_cnt); end
  endtask

  task automatic test_back_to_back();
    int lat, bad;
    logic [31:0] rd;
    @(posedge clk);
    @(negedge clk);
    force_ack = 1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h300;
    lat = -1; rd = '0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      if (cpu_ready) begin lat = c; rd = cpu_rdata; break; end
    end
    // Request is still held across the edge that completes the handshake.
    @(posedge clk); #1;
    checks++; if (cpu_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_pulse got %0d exp 0", cpu_ready); end
    cpu_req = 1'b0;
    bad = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (cpu_ready !== 1'b0 || mem_req !== 1'b0) bad++;
    end
    force_ack = 0;
    checks++; if (bad !== 0) begin errors++; $display("FAIL b2b_quiet got %0d active cycles exp 0", bad); end
    checks++; if (lat !== 1 || rd !== 32'h1000_0300) begin errors++; $display("FAIL b2b_hit got lat=%0d data=%h exp lat=1 data=10000300", lat, rd); end
    checks++; if (hit_cnt !== 16'd17) begin errors++; $display("FAIL b2b_hit_cnt got %0d exp 17", hit_cnt); end
  endtask

  task automatic test_mid_reset();
    logic [31:0] rd; int lat; bit reached;
    clear_log();
    @(posedge clk);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h400;
    reached = 0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk);
      if (log_addr.size() >= 2) begin reached = 1; break; end
    end
    checks++; if (!reached) begin errors++; $display("FAIL mid_reset_burst got %0d beats exp 2", log_addr.size()); end
    #2 reset = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL mid_reset_mem_req got %0d exp 0", mem_req); end
    checks++;
    if ({cpu_ready, cpu_rdata, mem_we, mem_addr, mem_wdata, hit_cnt, miss_cnt} !== '0) begin
      errors++; $display("FAIL mid_reset_outputs got rdy=%0d rd=%h we=%0d ma=%h wd=%h h=%0d m=%0d exp all 0",
                         cpu_ready, cpu_rdata, mem_we, mem_addr, mem_wdata, hit_cnt, miss_cnt);
    end
    cpu_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    cpu_access(1'b0, 32'h400, 32'h0, rd, lat);
    checks++; if (lat !== 6 || rd !== 32'h1000_0400) begin errors++; $display("FAIL post_reset_refill got lat=%0d data=%h exp lat=6 data=10000400", lat, rd); end
    cpu_access(1'b0, 32'h20, 32'h0, rd, lat);
    checks++; if (lat !== 6 || rd !== 32'h1000_0020) begin errors++; $display("FAIL post_reset_invalid got lat=%0d data=%h exp lat=6 data=10000020", lat, rd); end
    checks++; if (miss_cnt !== 16'd2 || hit_cnt !== 16'd0) begin errors++; $display("FAIL post_reset_counts got h=%0d m=%0d exp h=0 m=2", hit_cnt, miss_cnt); end
  endtask

  task automatic test_saturate();
    logic [31:0] rd; int lat, bad;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      cpu_access(1'b0, 32'h20, 32'h0, rd, lat);
      if (lat !== 1) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL sat_hits got %0d non-hit accesses exp 0", bad); end
    checks++; if (hit_cnt !== 16'd5) begin errors++; $display("FAIL sat_wide_hit_cnt got %0d exp 5", hit_cnt); end
    checks++; if (d2_hit_cnt !== 2'd3) begin errors++; $display("FAIL sat_narrow_hit_cnt got %0d exp 3", d2_hit_cnt); end
    checks++; if (d2_miss_cnt !== 2'd2) begin errors++; $display("FAIL sat_narrow_miss_cnt got %0d exp 2", d2_miss_cnt); end
  endtask

  initial begin
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 test_reset();
    @(negedge clk) reset = 1'b0;
    test_cold_write();
    test_read_hit();
    test_dirty_evict();
    test_fill_lines();
    test_delayed_ack();
    test_back_to_back();
    test_mid_reset();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
